// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_port_arbiter
// Description : Round-robin arbiter that merges NUM_PORTS word-wide requesters
//               onto a single line-wide DRAM command port. Reads are tagged
//               with {port, word index} in an in-order tag FIFO so the
//               returning line can be steered back to its requester and the
//               addressed word extracted with zero added latency.
// Ports       : clk, rst_x_async        - clock, async active-low reset
//               req_*                   - per-port request (valid/ready)
//               rd_valid/rd_word/rd_line - per-port read return
//               cmd_*                   - downstream line command
//               rsp_valid/rsp_data      - downstream read response
//               outstanding, rsp_err    - status
// Revision    : 1.0 - initial release
// ============================================================================
module dram_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int WORD_W    = 32,
    parameter int LINE_W    = 128,
    parameter int MAX_OUTST = 4
) (
    input  logic                            clk,
    input  logic                            rst_x_async,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_PORTS*WORD_W-1:0]     req_wdata,
    input  logic [NUM_PORTS*WORD_W/8-1:0]   req_mask,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            rd_valid,
    output logic [WORD_W-1:0]               rd_word,
    output logic [LINE_W-1:0]               rd_line,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic                            cmd_we,
    output logic [ADDR_W-1:0]               cmd_addr,
    output logic [LINE_W-1:0]               cmd_wdata,
    output logic [LINE_W/8-1:0]             cmd_strb,
    input  logic                            rsp_valid,
    input  logic [LINE_W-1:0]               rsp_data,
    output logic [$clog2(MAX_OUTST):0]      outstanding,
    output logic                            rsp_err
);

    localparam int c_ratio      = LINE_W / WORD_W;
    localparam int c_word_bytes = WORD_W / 8;
    localparam int c_line_bytes = LINE_W / 8;
    localparam int c_word_off   = $clog2(c_word_bytes);
    localparam int c_line_off   = $clog2(c_line_bytes);
    localparam int c_idx_w      = (c_ratio > 1) ? $clog2(c_ratio) : 1;
    localparam int c_port_w     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_ptr_w      = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int c_cnt_w      = $clog2(MAX_OUTST) + 1;
    localparam logic [ADDR_W-1:0] c_line_lo_mask = ADDR_W'((64'd1 << c_line_off) - 64'd1);

    // ------------------------------------------------------------------------
    // Reset: assertion clears state immediately through the async input;
    // deassertion is walked through two flops, and all state updates and
    // handshake outputs stay frozen until it emerges.
    // ------------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_active;

    always_ff @(posedge clk or negedge rst_x_async) begin
        if (!rst_x_async) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_active = r_rst_sync[1];

    // ------------------------------------------------------------------------
    // Round-robin grant, searching upward from r_rr_ptr.
    // ------------------------------------------------------------------------
    logic [c_port_w-1:0] r_rr_ptr;
    logic [c_port_w-1:0] w_grant;
    logic                w_any;

    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_any && req_valid[(int'(r_rr_ptr) + i) % NUM_PORTS]) begin
                w_any   = 1'b1;
                w_grant = c_port_w'((int'(r_rr_ptr) + i) % NUM_PORTS);
            end
        end
    end

    logic [ADDR_W-1:0]  w_sel_addr;
    logic [WORD_W-1:0]  w_sel_wdata;
    logic [c_word_bytes-1:0] w_sel_mask;
    logic               w_sel_we;
    logic [c_idx_w-1:0] w_idx;

    assign w_sel_addr  = req_addr[int'(w_grant)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata[int'(w_grant)*WORD_W +: WORD_W];
    assign w_sel_mask  = req_mask[int'(w_grant)*c_word_bytes +: c_word_bytes];
    assign w_sel_we    = req_we[w_grant];

    // Word position within the line; a one-word line has only position 0.
    generate
        if (c_ratio > 1) begin : g_idx_multi
            assign w_idx = w_sel_addr[c_line_off-1:c_word_off];
        end else begin : g_idx_single
            assign w_idx = '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Tag FIFO bookkeeping
    // ------------------------------------------------------------------------
    logic [c_port_w-1:0] r_tag_port [MAX_OUTST];
    logic [c_idx_w-1:0]  r_tag_idx  [MAX_OUTST];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_err;
    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [c_port_w-1:0] w_head_port;
    logic [c_idx_w-1:0]  w_head_idx;

    assign w_full      = (r_count == c_cnt_w'(MAX_OUTST));
    assign w_empty     = (r_count == '0);
    assign w_head_port = r_tag_port[r_rd_ptr];
    assign w_head_idx  = r_tag_idx[r_rd_ptr];

    // Writes are posted and bypass the tag FIFO, so only reads can stall on it.
    assign cmd_valid = w_active & w_any & (w_sel_we | ~w_full);
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_push    = w_accept & ~w_sel_we;
    assign w_pop     = w_active & rsp_valid & ~w_empty;

    assign cmd_we    = w_sel_we;
    assign cmd_addr  = w_sel_addr & ~c_line_lo_mask;
    assign cmd_wdata = {c_ratio{w_sel_wdata}};
    assign cmd_strb  = w_sel_we ? (c_line_bytes'(w_sel_mask) << (int'(w_idx) * c_word_bytes))
                                : '0;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign req_ready[p] = (w_grant == c_port_w'(p)) & w_accept;
            assign rd_valid[p]  = w_pop & (w_head_port == c_port_w'(p));
        end
    endgenerate

    assign rd_line     = rsp_data;
    assign rd_word     = WORD_W'(rsp_data >> (int'(w_head_idx) * WORD_W));
    assign outstanding = r_count;
    assign rsp_err     = r_err;

    // Tag storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_port[r_wr_ptr] <= w_grant;
            r_tag_idx[r_wr_ptr]  <= w_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_x_async) begin
        if (!rst_x_async) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else if (w_active) begin
            if (w_accept) begin
                r_rr_ptr <= (w_grant == c_port_w'(NUM_PORTS - 1)) ? '0 : w_grant + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(MAX_OUTST - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(MAX_OUTST - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A response with no tag to match is a protocol fault; latch it.
            if (rsp_valid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dram_port_arbiter
// Description : Directed bench for dram_port_arbiter (default parameters):
//               table of single-cycle arbitration vectors, then hand-written
//               sequences for tag-FIFO fill/drain, response steering, error
//               flag and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_port_arbiter;

    logic         clk = 1'b0;
    logic         rst_x_async = 1'b0;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_we = '0;
    logic [63:0]  req_addr = '0;
    logic [63:0]  req_wdata = '0;
    logic [7:0]   req_mask = '0;
    logic [1:0]   req_ready;
    logic [1:0]   rd_valid;
    logic [31:0]  rd_word;
    logic [127:0] rd_line;
    logic         cmd_valid;
    logic         cmd_ready = 1'b0;
    logic         cmd_we;
    logic [31:0]  cmd_addr;
    logic [127:0] cmd_wdata;
    logic [15:0]  cmd_strb;
    logic         rsp_valid = 1'b0;
    logic [127:0] rsp_data = '0;
    logic [2:0]   outstanding;
    logic         rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dram_port_arbiter #(
        .NUM_PORTS(2), .ADDR_W(32), .WORD_W(32), .LINE_W(128), .MAX_OUTST(4)
    ) dut (
        .clk(clk), .rst_x_async(rst_x_async),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_mask(req_mask), .req_ready(req_ready),
        .rd_valid(rd_valid), .rd_word(rd_word), .rd_line(rd_line),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .outstanding(outstanding), .rsp_err(rsp_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Apply one cycle of stimulus at the falling edge and settle.
    task automatic drive(input logic [1:0] v, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic crdy, input logic rv, input logic [127:0] rd);
        @(negedge clk);
        req_valid = v;
        req_we    = w;
        req_addr  = {a1, a0};
        cmd_ready = crdy;
        rsp_valid = rv;
        rsp_data  = rd;
        #1;
    endtask

    function automatic logic [127:0] mkline(input int k);
        return {32'(32'h4000_0000 + k), 32'(32'h3000_0000 + k),
                32'(32'h2000_0000 + k), 32'(32'h1000_0000 + k)};
    endfunction

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  m0, m1;
        logic        crdy;
        logic        e_cv;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [15:0] e_strb;
        logic [1:0]  e_rdy;
    } vec_t;

    vec_t vt [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [127:0] l1;
        logic [127:0] l2;
        logic [1:0]   exp_port [4];
        int           cyc;

        // rr_ptr sequence through the table: 0 ->1 ->0 ->0 ->1 ->1 ->1 ->1 ->0
        vt[0] = '{2'b01, 2'b01, 32'h104, 32'h0,   32'hAABBCCDD, 32'h0,        4'hF, 4'h0, 1'b1,
                  1'b1, 1'b1, 32'h100, 32'hAABBCCDD, 16'h00F0, 2'b01};
        vt[1] = '{2'b11, 2'b11, 32'h0,   32'h20C, 32'h0,        32'h11223344, 4'h0, 4'h3, 1'b1,
                  1'b1, 1'b1, 32'h200, 32'h11223344, 16'h3000, 2'b10};
        vt[2] = '{2'b11, 2'b11, 32'h0,   32'h0,   32'h01020304, 32'h0,        4'h5, 4'h0, 1'b0,
                  1'b1, 1'b1, 32'h0,   32'h01020304, 16'h0005, 2'b00};
        vt[3] = '{2'b11, 2'b11, 32'h0,   32'h0,   32'h01020304, 32'h0,        4'h5, 4'h0, 1'b1,
                  1'b1, 1'b1, 32'h0,   32'h01020304, 16'h0005, 2'b01};
        vt[4] = '{2'b10, 2'b00, 32'h0,   32'h18,  32'h0,        32'h55667788, 4'h0, 4'hF, 1'b0,
                  1'b1, 1'b0, 32'h10,  32'h55667788, 16'h0000, 2'b00};
        vt[5] = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,        32'h0,        4'h0, 4'h0, 1'b1,
                  1'b0, 1'b0, 32'h0,   32'h0,        16'h0000, 2'b00};
        vt[6] = '{2'b01, 2'b01, 32'h108, 32'h0,   32'hCAFEF00D, 32'h0,        4'h8, 4'h0, 1'b1,
                  1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 16'h0800, 2'b01};
        vt[7] = '{2'b11, 2'b11, 32'h0,   32'h3FC, 32'h0,        32'hDEADBEEF, 4'hF, 4'hF, 1'b1,
                  1'b1, 1'b1, 32'h3F0, 32'hDEADBEEF, 16'hF000, 2'b10};

        // ---------------- reset state, outputs gated regardless of inputs
        req_valid = 2'b11; req_we = 2'b11; rsp_valid = 1'b1; cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst cmd_valid", 128'(cmd_valid), 128'(0));
        chk("rst req_ready", 128'(req_ready), 128'(0));
        chk("rst rd_valid", 128'(rd_valid), 128'(0));
        chk("rst outstanding", 128'(outstanding), 128'(0));
        chk("rst rsp_err", 128'(rsp_err), 128'(0));

        // Deassert with a pending write held and cmd_ready low: the command
        // must appear only after the two-flop release.
        @(negedge clk);
        rsp_valid = 1'b0; cmd_ready = 1'b0; req_valid = 2'b01; req_we = 2'b01;
        rst_x_async = 1'b1;
        #1;
        chk("release cyc0 cmd_valid", 128'(cmd_valid), 128'(0));
        @(negedge clk); #1;
        chk("release cyc1 cmd_valid", 128'(cmd_valid), 128'(0));
        @(negedge clk); #1;
        chk("release cyc2 cmd_valid", 128'(cmd_valid), 128'(1));
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, '0);

        // ---------------- table-driven arbitration vectors
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = vt[i].valid;
            req_we    = vt[i].we;
            req_addr  = {vt[i].a1, vt[i].a0};
            req_wdata = {vt[i].d1, vt[i].d0};
            req_mask  = {vt[i].m1, vt[i].m0};
            cmd_ready = vt[i].crdy;
            #1;
            chk($sformatf("v%0d cmd_valid", i), 128'(cmd_valid), 128'(vt[i].e_cv));
            chk($sformatf("v%0d req_ready", i), 128'(req_ready), 128'(vt[i].e_rdy));
            if (vt[i].e_cv) begin
                chk($sformatf("v%0d cmd_we", i), 128'(cmd_we), 128'(vt[i].e_we));
                chk($sformatf("v%0d cmd_addr", i), 128'(cmd_addr), 128'(vt[i].e_addr));
                chk($sformatf("v%0d cmd_strb", i), 128'(cmd_strb), 128'(vt[i].e_strb));
                chk($sformatf("v%0d cmd_wdata", i), cmd_wdata, {4{vt[i].e_wd}});
            end
        end

        // ---------------- both ports read continuously (rr_ptr now 0)
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b00, 32'h0, 32'h8, 1'b1, 1'b0, '0);
            chk($sformatf("fill%0d req_ready", i), 128'(req_ready),
                128'((i % 2 == 0) ? 2'b01 : 2'b10));
            chk($sformatf("fill%0d outstanding", i), 128'(outstanding), 128'(i));
        end
        drive(2'b11, 2'b00, 32'h0, 32'h8, 1'b1, 1'b0, '0);
        chk("full cmd_valid", 128'(cmd_valid), 128'(0));
        chk("full req_ready", 128'(req_ready), 128'(0));
        chk("full outstanding", 128'(outstanding), 128'(4));

        // Response while full: pop only, no push in the same cycle.
        drive(2'b11, 2'b00, 32'h0, 32'h8, 1'b1, 1'b1, mkline(1));
        chk("fullpop rd_valid", 128'(rd_valid), 128'(2'b01));
        chk("fullpop rd_word", 128'(rd_word), 128'(32'h1000_0001));
        chk("fullpop req_ready", 128'(req_ready), 128'(0));
        drive(2'b11, 2'b00, 32'h0, 32'h8, 1'b1, 1'b0, '0);
        chk("after pop outstanding", 128'(outstanding), 128'(3));
        chk("after pop req_ready", 128'(req_ready), 128'(2'b01));
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, '0);
        chk("refill outstanding", 128'(outstanding), 128'(4));

        // Drain: FIFO order is port1(idx2), port0(idx0), port1, port0.
        exp_port[0] = 2'b10; exp_port[1] = 2'b01; exp_port[2] = 2'b10; exp_port[3] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, mkline(k + 2));
            chk($sformatf("drain%0d rd_valid", k), 128'(rd_valid), 128'(exp_port[k]));
            chk($sformatf("drain%0d rd_word", k), 128'(rd_word),
                128'((exp_port[k] == 2'b10) ? 32'(32'h3000_0000 + k + 2)
                                            : 32'(32'h1000_0000 + k + 2)));
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        chk("drained outstanding", 128'(outstanding), 128'(0));

        // ---------------- port1 read 0x8 then port0 read 0x0
        drive(2'b10, 2'b00, 32'h0, 32'h8, 1'b1, 1'b0, '0);
        chk("seq48 p1 ready", 128'(req_ready), 128'(2'b10));
        drive(2'b01, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, '0);
        chk("seq48 p0 ready", 128'(req_ready), 128'(2'b01));
        l1 = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
        l2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, l1);
        chk("seq48 L1 rd_valid", 128'(rd_valid), 128'(2'b10));
        chk("seq48 L1 rd_word", 128'(rd_word), 128'(l1[95:64]));
        chk("seq48 L1 rd_line", rd_line, l1);
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, l2);
        chk("seq48 L2 rd_valid", 128'(rd_valid), 128'(2'b01));
        chk("seq48 L2 rd_word", 128'(rd_word), 128'(l2[31:0]));

        // ---------------- unexpected response
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        chk("pre err rsp_err", 128'(rsp_err), 128'(0));
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, l1);
        chk("err rd_valid", 128'(rd_valid), 128'(0));
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        chk("err set", 128'(rsp_err), 128'(1));
        cyc = 0;
        repeat (3) begin
            drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, '0);
            cyc++;
        end
        chk($sformatf("err sticky after %0d cycles", cyc), 128'(rsp_err), 128'(1));

        // ---------------- reset with three reads in flight
        repeat (3) drive(2'b01, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, '0);
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        chk("inflight outstanding", 128'(outstanding), 128'(3));
        @(negedge clk);
        req_valid = 2'b11; req_we = 2'b11; cmd_ready = 1'b1; rsp_valid = 1'b1;
        rst_x_async = 1'b0;
        #1;
        chk("rst2 outstanding", 128'(outstanding), 128'(0));
        chk("rst2 rsp_err", 128'(rsp_err), 128'(0));
        chk("rst2 cmd_valid", 128'(cmd_valid), 128'(0));
        chk("rst2 req_ready", 128'(req_ready), 128'(0));
        chk("rst2 rd_valid", 128'(rd_valid), 128'(0));
        repeat (2) @(negedge clk);
        req_valid = 2'b00; rsp_valid = 1'b0; cmd_ready = 1'b0;
        rst_x_async = 1'b1;
        repeat (3) drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, l2);
        chk("stale rsp rd_valid", 128'(rd_valid), 128'(0));
        drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, '0);
        chk("stale rsp rsp_err", 128'(rsp_err), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
